mvm_sparse_scheduler: RTL and testbench

//  Sequencer in front of MVM_Accelerator: buffers one input vector, marks nonzero elements, then issues
//  MAC requests row by row for nonzero columns only (zero activations skipped). Sits between the

---
 rtl/mvm_sparse_scheduler_pkg.sv | 20 ++
 rtl/mvm_sparse_scheduler_if.sv | 64 ++++++
 rtl/mvm_sparse_scheduler_nz_pick.sv | 27 ++
 rtl/mvm_sparse_scheduler.sv | 137 +++++++++++++
 tb/tb_mvm_sparse_scheduler.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mvm_sparse_scheduler_pkg.sv
// Shared types and default sizing for the sparse MVM scheduler.
// Imported by the interface, picker and top.
package mvm_pkg;

  localparam int DEF_VEC_LEN = 8;
  localparam int DEF_ROWS    = 8;
  localparam int DEF_DATA_W  = 8;

  localparam int DEF_COL_W = $clog2(DEF_VEC_LEN);
  localparam int DEF_ROW_W =
    (DEF_ROWS > 1) ? $clog2(DEF_ROWS) : 1;
  localparam int DEF_CNT_W = DEF_COL_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/mvm_sparse_scheduler_if.sv
// Load, control and MAC beat bundle of the scheduler.
// master = scheduler side, slave = host/accelerator side.
interface mvm_sparse_scheduler_if
  import mvm_pkg::*;
#(
  parameter int VEC_LEN = DEF_VEC_LEN,
  parameter int ROWS    = DEF_ROWS,
  parameter int DATA_W  = DEF_DATA_W
);

  localparam int CW = $clog2(VEC_LEN);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW = CW + 1;

  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              start;
  logic              busy;
  logic              done;
  logic              mac_valid;
  logic              mac_ready;
  logic [RW-1:0]     mac_row;
  logic [CW-1:0]     mac_col;
  logic [DATA_W-1:0] mac_act;
  logic              mac_first;
  logic              mac_last;
  logic [SW-1:0]     skip_count;

  modport master (
    input  load_valid,
    input  load_data,
    input  start,
    input  mac_ready,
    output load_ready,
    output busy,
    output done,
    output mac_valid,
    output mac_row,
    output mac_col,
    output mac_act,
    output mac_first,
    output mac_last,
    output skip_count
  );

  modport slave (
    output load_valid,
    output load_data,
    output start,
    output mac_ready,
    input  load_ready,
    input  busy,
    input  done,
    input  mac_valid,
    input  mac_row,
    input  mac_col,
    input  mac_act,
    input  mac_first,
    input  mac_last,
    input  skip_count
  );

endinterface

// File: rtl/mvm_sparse_scheduler_nz_pick.sv
// Lowest-set-bit encoder over the column work mask.
// Gives index, onehot clear mask and exactly-one-bit flag.
module mvm_nz_pick #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] mask,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         single,
  output logic         any
);

  // scan high to low so the lowest set bit wins
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = W'(i);
    end
  end

  assign onehot = mask & (~mask + N'(1));
  assign any    = |mask;
  assign single = any &&
    ((mask & (mask - N'(1))) == '0);

endmodule

// File: rtl/mvm_sparse_scheduler.sv
// Sparse MVM sequencer: buffers one vector, then issues
// MAC beats row by row for nonzero columns only.
module mvm_sparse_scheduler
  import mvm_pkg::*;
#(
  parameter int VEC_LEN = DEF_VEC_LEN,
  parameter int ROWS    = DEF_ROWS,
  parameter int DATA_W  = DEF_DATA_W
) (
  input logic                   clk,
  input logic                   rst_n,
  mvm_sparse_scheduler_if.master bus
);

  localparam int CW = $clog2(VEC_LEN);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW = CW + 1;

  state_t            state;
  logic [DATA_W-1:0] vbuf [VEC_LEN];
  logic [VEC_LEN-1:0] nz;
  logic [VEC_LEN-1:0] work;
  logic [CW-1:0]     wr_ptr;
  logic              vec_full;
  logic [RW-1:0]     row;
  logic              first;
  logic [SW-1:0]     skip;

  logic [CW-1:0]      pick_idx;
  logic [VEC_LEN-1:0] pick_oh;
  logic               pick_one;
  logic               pick_any;
  logic [SW-1:0]      nz_cnt;

  logic load_hs;
  logic run_go;
  logic mac_hs;
  logic row_end;
  logic last_row;
  logic run;

  mvm_nz_pick #(.N(VEC_LEN)) u_pick (
    .mask   (work),
    .idx    (pick_idx),
    .onehot (pick_oh),
    .single (pick_one),
    .any    (pick_any)
  );

  // population count of the nonzero mask
  always_comb begin
    nz_cnt = '0;
    for (int i = 0; i < VEC_LEN; i++) begin
      nz_cnt = nz_cnt + SW'(nz[i]);
    end
  end

  assign run      = (state == RUN);
  assign load_hs  = (state == IDLE) && !vec_full
                    && bus.load_valid;
  assign run_go   = (state == IDLE) && vec_full
                    && bus.start;
  assign mac_hs   = run && bus.mac_ready;
  assign row_end  = pick_one || !pick_any;
  assign last_row = (row == RW'(ROWS - 1));

  assign bus.load_ready = (state == IDLE) && !vec_full;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.mac_valid  = run;
  assign bus.mac_row    = run ? row : '0;
  assign bus.mac_col    = run ? pick_idx : '0;
  assign bus.mac_act    = run ? vbuf[pick_idx] : '0;
  assign bus.mac_first  = run && first;
  assign bus.mac_last   = run && row_end;
  assign bus.skip_count = skip;

  // sequencer: load in IDLE, sweep rows in RUN, pulse DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      vec_full <= 1'b0;
      nz       <= '0;
      work     <= '0;
      row      <= '0;
      first    <= 1'b0;
      skip     <= '0;
      for (int i = 0; i < VEC_LEN; i++) begin
        vbuf[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (load_hs) begin
            vbuf[wr_ptr] <= bus.load_data;
            nz[wr_ptr]   <= (bus.load_data != '0);
            if (wr_ptr == CW'(VEC_LEN - 1)) begin
              vec_full <= 1'b1;
              wr_ptr   <= '0;
            end else begin
              wr_ptr <= wr_ptr + CW'(1);
            end
          end else if (run_go) begin
            state <= RUN;
            row   <= '0;
            work  <= nz;
            first <= 1'b1;
            skip  <= SW'(VEC_LEN) - nz_cnt;
          end
        end
        RUN: begin
          if (mac_hs) begin
            if (row_end) begin
              work  <= nz;
              first <= 1'b1;
              if (last_row) state <= DONE;
              else row <= row + RW'(1);
            end else begin
              work  <= work & ~pick_oh;
              first <= 1'b0;
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          vec_full <= 1'b0;
          row      <= '0;
          work     <= '0;
          first    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_sparse_scheduler.sv
// Self-checking bench for mvm_sparse_scheduler.
// Beat-list model plus literal pins on key results.
module tb_mvm_sparse_scheduler;
  import mvm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mvm_sparse_scheduler_if bus ();

  mvm_sparse_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int row;
    int col;
    int act;
    int first;
    int last;
  } beat_t;

  int checks = 0;
  int failures = 0;

  int    m_phase;
  int    m_cnt;
  int    m_vec [8];
  beat_t m_q [$];
  int    m_skip;

  int hs_seen = 0;
  logic mv_prev = 1'b0;
  int fb_col, fb_act, fb_first, fb_last;

  task automatic check(input string name,
                       input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d",
               name, act, exp);
    end
  endtask

  task automatic build_beats();
    int n;
    m_q.delete();
    m_skip = 0;
    for (int c = 0; c < 8; c++)
      if (m_vec[c] == 0) m_skip++;
    n = 8 - m_skip;
    for (int r = 0; r < 8; r++) begin
      if (n == 0) begin
        m_q.push_back('{r, 0, 0, 1, 1});
      end else begin
        int k;
        k = 0;
        for (int c = 0; c < 8; c++) begin
          if (m_vec[c] != 0) begin
            m_q.push_back('{r, c, m_vec[c],
                            int'(k == 0),
                            int'(k == n - 1)});
            k++;
          end
        end
      end
    end
  endtask

  // reference model: vector fill, beat list, done cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
      m_skip  = 0;
      m_q.delete();
    end else begin
      case (m_phase)
        0: begin
          if (bus.load_valid && m_cnt < 8) begin
            m_vec[m_cnt] = int'(bus.load_data);
            m_cnt++;
          end else if (bus.start && m_cnt == 8) begin
            build_beats();
            m_phase = 1;
          end
        end
        1: begin
          if (bus.mac_ready) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_phase = 2;
          end
        end
        default: begin
          m_phase = 0;
          m_cnt   = 0;
        end
      endcase
    end
  end

  // count accepted beats as seen on the DUT pins
  always @(posedge clk)
    if (rst_n && bus.mac_valid && bus.mac_ready)
      hs_seen++;

  // remember the first beat of every run
  always @(negedge clk) begin
    if (bus.mac_valid && !mv_prev) begin
      fb_col   = int'(bus.mac_col);
      fb_act   = int'(bus.mac_act);
      fb_first = int'(bus.mac_first);
      fb_last  = int'(bus.mac_last);
    end
    mv_prev = bus.mac_valid;
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    check("load_ready", int'(bus.load_ready),
          int'(m_phase == 0 && m_cnt < 8));
    check("busy", int'(bus.busy), int'(m_phase != 0));
    check("done", int'(bus.done), int'(m_phase == 2));
    check("mac_valid", int'(bus.mac_valid),
          int'(m_phase == 1));
    check("skip_count", int'(bus.skip_count), m_skip);
    if (m_phase == 1 && m_q.size() > 0) begin
      check("mac_row", int'(bus.mac_row), m_q[0].row);
      check("mac_col", int'(bus.mac_col), m_q[0].col);
      check("mac_act", int'(bus.mac_act), m_q[0].act);
      check("mac_first", int'(bus.mac_first),
            m_q[0].first);
      check("mac_last", int'(bus.mac_last), m_q[0].last);
    end
  end

  task automatic load_vec(input int v [8]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.load_valid = 1'b1;
      bus.load_data  = 8'(v[i]);
    end
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  task automatic run_vec(input bit rnd, output int beats);
    int base;
    bit got;
    base = hs_seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mac_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      if (bus.done) begin
        got = 1'b1;
      end else begin
        if (rnd) bus.mac_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    if (!got) check("done_timeout", 0, 1);
    beats = hs_seen - base;
    bus.mac_ready = 1'b1;
  endtask

  initial begin
    int v [8];
    int beats;
    bit found;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.start      = 1'b0;
    bus.mac_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_load_ready", int'(bus.load_ready), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_mac_valid", int'(bus.mac_valid), 0);
    check("rst_skip", int'(bus.skip_count), 0);
    rst_n = 1'b1;

    // sparse vector, always-ready accelerator
    v = '{0, 5, 0, 0, 7, 0, 0, 1};
    load_vec(v);
    run_vec(1'b0, beats);
    check("sparse_beats", beats, 24);
    check("sparse_skip", int'(bus.skip_count), 5);
    check("sparse_fb_col", fb_col, 1);
    check("sparse_fb_act", fb_act, 5);
    check("sparse_fb_first", fb_first, 1);
    check("sparse_fb_last", fb_last, 0);
    @(negedge clk);
    check("done_one_cycle", int'(bus.done), 0);
    check("reload_ready", int'(bus.load_ready), 1);

    // all-zero vector
    v = '{0, 0, 0, 0, 0, 0, 0, 0};
    load_vec(v);
    run_vec(1'b0, beats);
    check("zero_beats", beats, 8);
    check("zero_skip", int'(bus.skip_count), 8);
    check("zero_fb_first", fb_first, 1);
    check("zero_fb_last", fb_last, 1);

    // dense vector with early/coincident start
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.load_valid = 1'b1;
      bus.load_data  = 8'(i + 1);
    end
    @(negedge clk);
    bus.load_valid = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("early_start_busy", int'(bus.busy), 0);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'd8;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.load_data = 8'd99;
    check("same_cycle_busy", int'(bus.busy), 0);
    check("full_ready", int'(bus.load_ready), 0);
    @(negedge clk);
    bus.load_valid = 1'b0;
    check("ninth_busy", int'(bus.busy), 0);
    run_vec(1'b1, beats);
    check("dense_beats", beats, 64);
    check("dense_skip", int'(bus.skip_count), 0);
    check("dense_fb_act", fb_act, 1);

    // back-to-back run with a fresh vector
    v = '{0, 0, 3, 0, 0, 0, 9, 0};
    load_vec(v);
    run_vec(1'b0, beats);
    check("b2b_beats", beats, 16);
    check("b2b_skip", int'(bus.skip_count), 6);
    check("b2b_fb_col", fb_col, 2);
    check("b2b_fb_act", fb_act, 3);

    // reset in the middle of row 3
    v = '{4, 4, 0, 0, 0, 0, 0, 0};
    load_vec(v);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mac_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (bus.mac_valid && bus.mac_row == 3) found = 1'b1;
      else @(negedge clk);
    end
    check("row3_reached", int'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_valid", int'(bus.mac_valid), 0);
    check("abort_ready", int'(bus.load_ready), 1);
    check("abort_done", int'(bus.done), 0);
    check("abort_skip", int'(bus.skip_count), 0);
    check("abort_row", int'(bus.mac_row), 0);
    check("abort_last", int'(bus.mac_last), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
